// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised synchronous up/down counter with load,
// enable, direction, wrap/saturate boundary handling, combinational
// terminal count and a registered one-cycle boundary-event pulse.
//
// The RUN/HOLD mode machine is folded into the count register: the
// per-edge operation is decoded from the inputs (reset and load act as
// override transitions), and the next count is computed from it.
module updown_counter_n #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam bit               SAT   = (SATURATE != 0);

  // Operation selected on each edge, highest priority first: CLR > LOAD > RUN > HOLD
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_RUN  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_C);
  assign at_zero = (count == ZERO_C);

  // Clamp loads into 0..MAX_VAL; a full-range modulus needs no compare.
  if (MAX_VAL == 2**WIDTH-1) begin : g_noclamp
    assign load_clamp = load_val;
  end else begin : g_clamp
    assign load_clamp = (load_val > MAX_C) ? MAX_C : load_val;
  end

  // Mode decode: en selects RUN vs HOLD, reset and load override it
  always_comb begin
    op = OP_HOLD;
    if (!reset_n)  op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_RUN;
  end

  // Next count / boundary-event computation for the selected operation
  always_comb begin
    cnt_nxt = count;
    ovf_nxt = 1'b0;
    case (op)
      OP_CLR: begin
        cnt_nxt = ZERO_C;
      end
      OP_LOAD: begin
        cnt_nxt = load_clamp;
      end
      OP_RUN: begin
        if (up_dn) begin
          if (at_max) begin
            cnt_nxt = SAT ? MAX_C : ZERO_C;
            ovf_nxt = 1'b1;
          end else begin
            cnt_nxt = count + ONE_C;
          end
        end else begin
          if (at_zero) begin
            cnt_nxt = SAT ? ZERO_C : MAX_C;
            ovf_nxt = 1'b1;
          end else begin
            cnt_nxt = count - ONE_C;
          end
        end
      end
      default: begin
        cnt_nxt = count;
      end
    endcase
  end

  // State register: count and the one-cycle boundary pulse
  always_ff @(posedge clk) begin
    count <= cnt_nxt;
    ovf   <= ovf_nxt;
  end

  // Terminal count follows direction immediately, independent of en
  always_comb begin
    tc = up_dn ? at_max : at_zero;
  end

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n. Four instances with different
// width/modulus/mode share one stimulus; each is tracked by an arithmetic
// reference model and checked after every edge.
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       up_dn = 1'b0;

  logic [3:0] c_dec, c_sat, c_def;
  logic [2:0] c_odd;
  logic       t_dec, t_sat, t_def, t_odd;
  logic       o_dec, o_sat, o_def, o_odd;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance configuration: 0=decade wrap, 1=hex saturate, 2=default, 3=mod-6 saturate
  int p_max [4] = '{9, 15, 15, 5};
  int p_sat [4] = '{0, 1, 0, 1};
  int p_mask[4] = '{15, 15, 15, 7};

  int m_cnt[4];
  int m_ovf[4];

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_dec (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(c_dec), .tc(t_dec), .ovf(o_dec));

  updown_counter_n #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(c_sat), .tc(t_sat), .ovf(o_sat));

  updown_counter_n #(.WIDTH(4)) u_def (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(c_def), .tc(t_def), .ovf(o_def));

  updown_counter_n #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1)) u_odd (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .load_val(load_val[2:0]),
    .up_dn(up_dn), .count(c_odd), .tc(t_odd), .ovf(o_odd));

  function automatic logic [31:0] dut_cnt(int i);
    case (i)
      0: return {28'b0, c_dec};
      1: return {28'b0, c_sat};
      2: return {28'b0, c_def};
      default: return {29'b0, c_odd};
    endcase
  endfunction

  function automatic logic dut_ovf(int i);
    case (i)
      0: return o_dec;
      1: return o_sat;
      2: return o_def;
      default: return o_odd;
    endcase
  endfunction

  function automatic logic dut_tc(int i);
    case (i)
      0: return t_dec;
      1: return t_sat;
      2: return t_def;
      default: return t_odd;
    endcase
  endfunction

  // Reference behaviour of one edge, in plain integer arithmetic
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int v;
      if (!reset_n) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        v = int'(load_val) & p_mask[i];
        m_cnt[i] = (v > p_max[i]) ? p_max[i] : v;
        m_ovf[i] = 0;
      end else if (en) begin
        v = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (v > p_max[i] || v < 0) begin
          m_ovf[i] = 1;
          if (p_sat[i] != 0) v = m_cnt[i];
          else               v = (v < 0) ? p_max[i] : 0;
        end else begin
          m_ovf[i] = 0;
        end
        m_cnt[i] = v;
      end else begin
        m_ovf[i] = 0;
      end
    end
  endtask

  function automatic int model_tc(int i);
    return up_dn ? int'(m_cnt[i] == p_max[i]) : int'(m_cnt[i] == 0);
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd7; up_dn = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut_cnt(i) !== 0 || dut_ovf(i) !== 1'b0 || dut_tc(i) !== 1'b1) begin
        n_bad++;
        $display("FAIL reset[%0d]: got cnt=%0d ovf=%b tc=%b, want cnt=0 ovf=0 tc=1",
                 i, dut_cnt(i), dut_ovf(i), dut_tc(i));
      end
    end
  endtask

  task automatic test_wrap_up();
    int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    reset_n = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (c_dec !== 4'(exp_seq[k]) || o_dec !== (exp_seq[k] == 0) || t_dec !== (exp_seq[k] == 9)) begin
        n_bad++;
        $display("FAIL wrap_up step %0d: got cnt=%0d ovf=%b tc=%b, want cnt=%0d ovf=%b tc=%b",
                 k, c_dec, o_dec, t_dec, exp_seq[k], exp_seq[k] == 0, exp_seq[k] == 9);
      end
    end
  endtask

  task automatic test_wrap_down();
    load = 1'b1; load_val = 4'd0; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    n_cmp++;
    if (c_dec !== 4'd9 || o_dec !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_down first: got cnt=%0d ovf=%b, want cnt=9 ovf=1", c_dec, o_dec);
    end
    tick();
    n_cmp++;
    if (c_dec !== 4'd8 || o_dec !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_down second: got cnt=%0d ovf=%b, want cnt=8 ovf=0", c_dec, o_dec);
    end
  endtask

  task automatic test_saturate();
    int exp_ovf[3] = '{0, 1, 1};
    load = 1'b1; load_val = 4'd14; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (c_sat !== 4'd15 || o_sat !== exp_ovf[k][0]) begin
        n_bad++;
        $display("FAIL saturate step %0d: got cnt=%0d ovf=%b, want cnt=15 ovf=%0d",
                 k, c_sat, o_sat, exp_ovf[k]);
      end
    end
    n_cmp++;
    if (t_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate tc_up: got %b, want 1", t_sat);
    end
    up_dn = 1'b0; #1;
    n_cmp++;
    if (t_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate tc_dir: got %b, want 0", t_sat);
    end
    tick();
    n_cmp++;
    if (c_sat !== 4'd14 || o_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate down: got cnt=%0d ovf=%b, want cnt=14 ovf=0", c_sat, o_sat);
    end
  endtask

  task automatic test_load();
    en = 1'b1; load = 1'b1; load_val = 4'd13; up_dn = 1'b1;
    tick();
    n_cmp++;
    if (c_dec !== 4'd9 || o_dec !== 1'b0 || c_odd !== 3'd5) begin
      n_bad++;
      $display("FAIL load_clamp: got dec=%0d ovf=%b odd=%0d, want dec=9 ovf=0 odd=5",
               c_dec, o_dec, c_odd);
    end
    load_val = 4'd3;
    for (int k = 0; k < 2; k++) begin
      up_dn = ~up_dn;
      tick();
      n_cmp++;
      if (c_dec !== 4'd3 || c_sat !== 4'd3) begin
        n_bad++;
        $display("FAIL load_prio step %0d: got dec=%0d sat=%0d, want 3", k, c_dec, c_sat);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_hold_reset();
    int exp_run[2] = '{1, 2};
    load = 1'b1; load_val = 4'd5; tick();
    load = 1'b0; en = 1'b0; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (c_dec !== 4'd5 || o_dec !== 1'b0) begin
        n_bad++;
        $display("FAIL hold step %0d: got cnt=%0d ovf=%b, want cnt=5 ovf=0", k, c_dec, o_dec);
      end
    end
    en = 1'b1; reset_n = 1'b0;
    tick();
    n_cmp++;
    if (c_dec !== 4'd0 || o_dec !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got cnt=%0d ovf=%b, want cnt=0 ovf=0", c_dec, o_dec);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (c_dec !== 4'(exp_run[k])) begin
        n_bad++;
        $display("FAIL resume step %0d: got cnt=%0d, want %0d", k, c_dec, exp_run[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset_n  = ($urandom_range(0, 39) != 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 9) < 7);
      up_dn    = ($urandom_range(0, 3) != 0) ^ (k >= 200);
      load_val = 4'($urandom_range(0, 15));
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dut_cnt(i) !== 32'(m_cnt[i]) || dut_ovf(i) !== m_ovf[i][0] ||
            dut_tc(i) !== model_tc(i) != 0) begin
          n_bad++;
          $display("FAIL random[%0d] inst %0d: got cnt=%0d ovf=%b tc=%b, want cnt=%0d ovf=%0d tc=%0d",
                   k, i, dut_cnt(i), dut_ovf(i), dut_tc(i), m_cnt[i], m_ovf[i], model_tc(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0;
    end
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_hold_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
